// File: rtl/cvp14_pkg.sv
// CVP14 shared definitions: opcode set, vector geometry and the
// vector memory sequencer state encoding.
package cvp14_pkg;

    localparam int unsigned NUM_ELEM = 16;
    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 16;

    typedef enum logic [3:0] {
        OP_VADD = 4'b0000,
        OP_VDOT = 4'b0001,
        OP_SMUL = 4'b0010,
        OP_SST  = 4'b0011,
        OP_VLD  = 4'b0100,
        OP_VST  = 4'b0101,
        OP_SLL  = 4'b0110,
        OP_SLH  = 4'b0111,
        OP_J    = 4'b1000,
        OP_NOP  = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN
    } vmemState_e;

endpackage

// File: rtl/vmem_agen.sv
// Element counter and address generator for vmem_seq: issue-side base+k,
// a one-cycle-late copy for the return path, and sticky carry-out detect.
module vmem_agen #(
    parameter int unsigned NUM_ELEM = 16,
    parameter int unsigned AW       = 16
) (
    input  logic                        Clk1,
    input  logic                        Reset,
    input  logic                        load,
    input  logic                        step,
    input  logic [AW-1:0]               baseAddr,
    output logic [AW-1:0]               issAddr,
    output logic [$clog2(NUM_ELEM)-1:0] issIdx,
    output logic [AW-1:0]               retAddr,
    output logic [$clog2(NUM_ELEM)-1:0] retIdx,
    output logic                        last,
    output logic                        wrap
);

    localparam int unsigned IW = $clog2(NUM_ELEM);

    logic          carry;
    logic [AW-1:0] addrNext;

    // Incrementing the running address instead of re-adding base+k keeps
    // the carry-out visible in the same cycle the wrapped address appears.
    assign {carry, addrNext} = {1'b0, issAddr} + {{AW{1'b0}}, 1'b1};
    assign last = (issIdx == IW'(NUM_ELEM - 1));

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            issAddr <= '0;
            issIdx  <= '0;
            retAddr <= '0;
            retIdx  <= '0;
            wrap    <= 1'b0;
        end else begin
            retAddr <= issAddr;
            retIdx  <= issIdx;
            if (load) begin
                issAddr <= baseAddr;
                issIdx  <= '0;
                wrap    <= 1'b0;
            end else if (step) begin
                issAddr <= addrNext;
                issIdx  <= issIdx + IW'(1);
                if (carry) begin
                    wrap <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/vmem_seq.sv
// CVP14 vector load/store sequencer: streams NUM_ELEM elements between the
// memory bus and one vector register through the vector file serial port.
module vmem_seq #(
    parameter int unsigned NUM_ELEM = cvp14_pkg::NUM_ELEM,
    parameter int unsigned DW       = cvp14_pkg::DW,
    parameter int unsigned AW       = cvp14_pkg::AW
) (
    input  logic                        Clk1,
    input  logic                        Reset,
    input  logic                        Start,
    input  logic [3:0]                  Op,
    input  logic [AW-1:0]               BaseAddr,
    input  logic [2:0]                  VSel,
    output logic                        Busy,
    output logic                        Done,
    output logic                        AddrWrap,
    output logic [AW-1:0]               Addr,
    output logic                        RD,
    output logic                        WR,
    output logic [DW-1:0]               DataOut,
    input  logic [DW-1:0]               DataIn,
    output logic [2:0]                  VAddr,
    output logic [$clog2(NUM_ELEM)-1:0] VIdx,
    output logic                        VRD_s,
    output logic                        VWR_s,
    output logic [DW-1:0]               VDataOut_s,
    input  logic [DW-1:0]               VDataIn_s
);

    import cvp14_pkg::*;

    localparam int unsigned IW = $clog2(NUM_ELEM);

    vmemState_e    state;
    logic          opSt;
    logic [2:0]    vSelQ;
    logic          accept;
    logic          step;
    logic          last;
    logic [AW-1:0] issAddr;
    logic [AW-1:0] retAddr;
    logic [IW-1:0] issIdx;
    logic [IW-1:0] retIdx;

    assign accept = (state == IDLE) && Start && ((Op == OP_VLD) || (Op == OP_VST));
    assign step   = (state == ISSUE) && !last;

    vmem_agen #(
        .NUM_ELEM(NUM_ELEM),
        .AW      (AW)
    ) u_agen (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .load    (accept),
        .step    (step),
        .baseAddr(BaseAddr),
        .issAddr (issAddr),
        .issIdx  (issIdx),
        .retAddr (retAddr),
        .retIdx  (retIdx),
        .last    (last),
        .wrap    (AddrWrap)
    );

    // Loads address memory on issue and the vector file on return;
    // stores do the opposite, so the two sides swap counter copies.
    assign Addr  = opSt ? retAddr : issAddr;
    assign VIdx  = opSt ? issIdx  : retIdx;
    assign VAddr = vSelQ;

    // Return data arrives the cycle after its read strobe, in the same cycle
    // as the matching write strobe, so it is forwarded rather than registered.
    assign DataOut    = WR    ? VDataIn_s : '0;
    assign VDataOut_s = VWR_s ? DataIn    : '0;

    always_ff @(posedge Clk1 or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            opSt  <= 1'b0;
            vSelQ <= '0;
            Busy  <= 1'b0;
            Done  <= 1'b0;
            RD    <= 1'b0;
            WR    <= 1'b0;
            VRD_s <= 1'b0;
            VWR_s <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (accept) begin
                        opSt  <= (Op == OP_VST);
                        vSelQ <= VSel;
                        Busy  <= 1'b1;
                        RD    <= (Op == OP_VLD);
                        VRD_s <= (Op == OP_VST);
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    VWR_s <= !opSt;
                    WR    <= opSt;
                    if (last) begin
                        RD    <= 1'b0;
                        VRD_s <= 1'b0;
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    VWR_s <= 1'b0;
                    WR    <= 1'b0;
                    Done  <= 1'b1;
                    state <= FIN;
                end
                FIN: begin
                    Done  <= 1'b0;
                    Busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vmem_seq.sv
// Scoreboard bench for vmem_seq: stimulus queues expected bus beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_vmem_seq;

    typedef struct packed {
        int          cyc;
        logic [15:0] a;
        logic [15:0] d;
        logic [3:0]  idx;
        logic [2:0]  v;
    } beat_t;

    localparam int Q_RD = 0, Q_VWR = 1, Q_VRD = 2, Q_WR = 3, Q_DONE = 4;
    localparam int BIG  = 32'h7fffffff;

    logic        Clk1 = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [3:0]  Op = 4'h0;
    logic [15:0] BaseAddr = 16'h0;
    logic [2:0]  VSel = 3'h0;
    logic        Busy, Done, AddrWrap, RD, WR, VRD_s, VWR_s;
    logic [15:0] Addr, DataOut, VDataOut_s;
    logic [15:0] DataIn = 16'h0;
    logic [15:0] VDataIn_s = 16'h0;
    logic [2:0]  VAddr;
    logic [3:0]  VIdx;

    int    total = 0;
    int    bad = 0;
    int    edges = 0;
    beat_t q[5][$];
    int    busyFrom = 1, busyTo = 0;
    int    oldSet = BIG, curSet = BIG, clearAt = 0;

    vmem_seq #(.NUM_ELEM(16), .DW(16), .AW(16)) dut (
        .Clk1(Clk1), .Reset(Reset), .Start(Start), .Op(Op), .BaseAddr(BaseAddr),
        .VSel(VSel), .Busy(Busy), .Done(Done), .AddrWrap(AddrWrap), .Addr(Addr),
        .RD(RD), .WR(WR), .DataOut(DataOut), .DataIn(DataIn), .VAddr(VAddr),
        .VIdx(VIdx), .VRD_s(VRD_s), .VWR_s(VWR_s), .VDataOut_s(VDataOut_s),
        .VDataIn_s(VDataIn_s)
    );

    always #5 Clk1 = ~Clk1;
    always @(posedge Clk1) edges <= edges + 1;

    function automatic logic [15:0] memVal(input logic [15:0] a);
        return 16'hA000 + (a - 16'h0100);
    endfunction

    // Memory and vector file: registered read data, one cycle after the strobe.
    always @(posedge Clk1) begin
        if (RD)    DataIn    <= memVal(Addr);
        if (VRD_s) VDataIn_s <= 16'h5A00 + {12'h0, VIdx};
    end

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got %0h want %0h", nm, edges, act, exp);
        end
    endtask

    task automatic stream(input int s, input logic strobe, input beat_t obs, input string nm);
        beat_t e;
        if (strobe) begin
            if (q[s].size() == 0) begin
                total++;
                bad++;
                $display("FAIL %s unexpected beat: got %0h want none", nm, obs);
            end else begin
                e = q[s].pop_front();
                check(nm, obs, e);
            end
        end else if (q[s].size() != 0 && q[s][0].cyc <= edges) begin
            e = q[s].pop_front();
            total++;
            bad++;
            $display("FAIL %s missing beat: got none want %0h", nm, e);
        end
    endtask

    always @(negedge Clk1) begin
        int now;
        now = edges;
        stream(Q_RD,   RD,    '{now, Addr, 16'h0, 4'h0, VAddr}, "rd");
        stream(Q_VWR,  VWR_s, '{now, 16'h0, VDataOut_s, VIdx, VAddr}, "vwr");
        stream(Q_VRD,  VRD_s, '{now, 16'h0, 16'h0, VIdx, VAddr}, "vrd");
        stream(Q_WR,   WR,    '{now, Addr, DataOut, 4'h0, VAddr}, "wr");
        stream(Q_DONE, Done,  '{now, 16'h0, 16'h0, 4'h0, 3'h0}, "done");
        check("busy", Busy, (now >= busyFrom && now <= busyTo));
        check("addrwrap", AddrWrap, (now < clearAt) ? (now >= oldSet) : (now >= curSet));
        check("rd_wr_excl", RD & WR, 1'b0);
    end

    task automatic expectXfer(input logic [3:0] op, input logic [15:0] base,
                              input logic [2:0] vs, input int s);
        logic [15:0] a;
        int d;
        for (int k = 0; k < 16; k++) begin
            a = base + 16'(k);
            if (op == 4'b0100) begin
                q[Q_RD].push_back('{s + 1 + k, a, 16'h0, 4'h0, vs});
                q[Q_VWR].push_back('{s + 2 + k, 16'h0, memVal(a), 4'(k), vs});
            end else begin
                q[Q_VRD].push_back('{s + 1 + k, 16'h0, 16'h0, 4'(k), vs});
                q[Q_WR].push_back('{s + 2 + k, a, 16'h5A00 + 16'(k), 4'h0, vs});
            end
        end
        q[Q_DONE].push_back('{s + 18, 16'h0, 16'h0, 4'h0, 3'h0});
        busyFrom = s + 1;
        busyTo   = s + 18;
        oldSet   = curSet;
        clearAt  = s + 1;
        d        = 65536 - int'(base);
        curSet   = (d < 16) ? s + 1 + d : BIG;
    endtask

    // Called at a negedge (cycle 0); returns at the next negedge (cycle 1).
    task automatic pulse(input logic [3:0] op, input logic [15:0] base,
                         input logic [2:0] vs, input bit acc);
        Start = 1'b1;
        Op = op;
        BaseAddr = base;
        VSel = vs;
        if (acc) expectXfer(op, base, vs, edges);
        @(negedge Clk1);
        Start = 1'b0;
    endtask

    task automatic waitIdle();
        int left;
        for (int i = 0; i < 60; i++) begin
            left = 0;
            for (int j = 0; j < 5; j++) left += q[j].size();
            if (left == 0) break;
            @(negedge Clk1);
        end
        check("drain_timeout", left, 0);
        repeat (2) @(negedge Clk1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 Reset = 1'b0;
        repeat (3) @(negedge Clk1);
        check("por_strobes", {Busy, Done, AddrWrap, RD, WR, VRD_s, VWR_s}, 7'h0);
        check("por_addr", {Addr, DataOut, VDataOut_s}, 48'h0);
        check("por_vidx", {VIdx, VAddr}, 7'h0);
        Reset = 1'b1;
        @(negedge Clk1);

        pulse(4'b0100, 16'h0100, 3'd3, 1'b1);
        waitIdle();
        pulse(4'b0101, 16'h0200, 3'd5, 1'b1);
        waitIdle();

        pulse(4'b0100, 16'hFFF8, 3'd1, 1'b1);
        repeat (4) @(negedge Clk1);
        pulse(4'b0100, 16'h0800, 3'd2, 1'b0);
        waitIdle();
        pulse(4'b0000, 16'h0700, 3'd1, 1'b0);
        repeat (25) @(negedge Clk1);

        pulse(4'b0100, 16'h0300, 3'd2, 1'b1);
        repeat (17) @(negedge Clk1);
        pulse(4'b0101, 16'h0500, 3'd4, 1'b0);
        pulse(4'b0100, 16'h0400, 3'd6, 1'b1);
        waitIdle();

        pulse(4'b0101, 16'h0200, 3'd5, 1'b1);
        repeat (5) @(negedge Clk1);
        @(posedge Clk1);
        #2;
        for (int j = 0; j < 5; j++) q[j].delete();
        busyTo  = 0;
        curSet  = BIG;
        clearAt = 0;
        Reset   = 1'b0;
        #1;
        check("rst_strobes", {Busy, Done, AddrWrap, RD, WR, VRD_s, VWR_s}, 7'h0);
        check("rst_addr", {Addr, DataOut, VDataOut_s}, 48'h0);
        check("rst_vidx", {VIdx, VAddr}, 7'h0);
        repeat (2) @(negedge Clk1);
        Reset = 1'b1;
        @(negedge Clk1);
        pulse(4'b0100, 16'h0100, 3'd3, 1'b1);
        waitIdle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
